// File: rtl/cdb_arbiter.sv
//------------------------------------------------------------------------------
// cdb_arbiter
//
// Shares the common data bus between the ALU reservation station and the
// load/store buffer. Each producer writes into a private circular FIFO. A
// round-robin arbiter pops at most one head entry per cycle into a registered
// broadcast bus that the ROB, RS and LSB consume.
//
// Parameters:
//   ROB_WIDTH   width of the ROB index carried with each result
//   FIFO_DEPTH  entries per producer FIFO (power of two, >= 2)
//
// Ports:
//   clk_in        system clock
//   rst_in        synchronous active-low reset
//   rdy_in        global ready; low freezes all state
//   clear_in      ROB mispredict flush pulse (effective only with rdy_in)
//   alu_valid / alu_rob_id / alu_value   ALU result input
//   alu_full      ALU FIFO full; ALU must hold alu_valid low
//   lsb_valid / lsb_rob_id / lsb_value   LSB result input
//   lsb_full      LSB FIFO full
//   cdb_valid / cdb_src / cdb_rob_id / cdb_value   registered broadcast
//                 (cdb_src: 0 = ALU, 1 = LSB)
//   overflow_err  sticky flag, set when a push arrives at a full FIFO;
//                 cleared by reset only
//
// Optional feature (macro CDB_BYPASS_EN):
//   When both FIFOs are empty an incoming result is loaded straight into the
//   broadcast register, skipping its FIFO. With both inputs valid, the
//   round-robin winner bypasses and the loser is pushed.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module cdb_arbiter #(
    parameter int unsigned ROB_WIDTH  = 4,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 clear_in,
    input  logic                 alu_valid,
    input  logic [ROB_WIDTH-1:0] alu_rob_id,
    input  logic [31:0]          alu_value,
    output logic                 alu_full,
    input  logic                 lsb_valid,
    input  logic [ROB_WIDTH-1:0] lsb_rob_id,
    input  logic [31:0]          lsb_value,
    output logic                 lsb_full,
    output logic                 cdb_valid,
    output logic                 cdb_src,
    output logic [ROB_WIDTH-1:0] cdb_rob_id,
    output logic [31:0]          cdb_value,
    output logic                 overflow_err
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LSB = 1'b1
    } src_e;

    // Index 0 = ALU, index 1 = LSB throughout.
    logic [1:0]           in_valid;
    logic [ROB_WIDTH-1:0] in_rob [2];
    logic [31:0]          in_val [2];
    logic [1:0]           fifo_ne;
    logic [1:0]           fifo_full;
    logic [ROB_WIDTH-1:0] head_rob [2];
    logic [31:0]          head_val [2];
    logic [1:0]           push;
    logic [1:0]           pop;

    logic do_clear;
    logic do_step;

    logic grant_valid;
    src_e grant_src;
    logic byp_valid;
    src_e byp_src;
    src_e rr_pref;

    src_e                 last_grant_q, last_grant_d;
    logic                 cdb_valid_q,  cdb_valid_d;
    src_e                 cdb_src_q,    cdb_src_d;
    logic [ROB_WIDTH-1:0] cdb_rob_id_q, cdb_rob_id_d;
    logic [31:0]          cdb_value_q,  cdb_value_d;
    logic                 overflow_q,   overflow_d;

    assign in_valid  = {lsb_valid, alu_valid};
    assign in_rob[0] = alu_rob_id;
    assign in_rob[1] = lsb_rob_id;
    assign in_val[0] = alu_value;
    assign in_val[1] = lsb_value;

    assign do_clear = rdy_in && clear_in;
    assign do_step  = rdy_in && !clear_in;

    //--------------------------------------------------------------------------
    // Per-source circular FIFOs
    //--------------------------------------------------------------------------
    for (genvar g = 0; g < 2; g++) begin : g_fifo
        logic [ROB_WIDTH-1:0] rob_mem_q [FIFO_DEPTH];
        logic [ROB_WIDTH-1:0] rob_mem_d [FIFO_DEPTH];
        logic [31:0]          val_mem_q [FIFO_DEPTH];
        logic [31:0]          val_mem_d [FIFO_DEPTH];
        logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
        logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
        logic [CNT_W-1:0]     count_q,  count_d;

        assign fifo_ne[g]   = (count_q != '0);
        assign fifo_full[g] = (count_q == CNT_FULL);
        assign head_rob[g]  = rob_mem_q[rd_ptr_q];
        assign head_val[g]  = val_mem_q[rd_ptr_q];

        always_comb begin
            rob_mem_d = rob_mem_q;
            val_mem_d = val_mem_q;
            wr_ptr_d  = wr_ptr_q;
            rd_ptr_d  = rd_ptr_q;
            count_d   = count_q;
            if (do_clear) begin
                wr_ptr_d = '0;
                rd_ptr_d = '0;
                count_d  = '0;
            end else if (do_step) begin
                if (push[g]) begin
                    rob_mem_d[wr_ptr_q] = in_rob[g];
                    val_mem_d[wr_ptr_q] = in_val[g];
                    wr_ptr_d            = wr_ptr_q + 1'b1;
                end
                if (pop[g]) begin
                    rd_ptr_d = rd_ptr_q + 1'b1;
                end
                case ({push[g], pop[g]})
                    2'b10:   count_d = count_q + 1'b1;
                    2'b01:   count_d = count_q - 1'b1;
                    default: count_d = count_q;
                endcase
            end
        end

        always_ff @(posedge clk_in) begin
            if (!rst_in) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
                count_q  <= count_d;
            end
        end

        // Payload storage needs no reset; occupancy is tracked by count_q.
        always_ff @(posedge clk_in) begin
            rob_mem_q <= rob_mem_d;
            val_mem_q <= val_mem_d;
        end
    end

    assign alu_full = fifo_full[0];
    assign lsb_full = fifo_full[1];

    //--------------------------------------------------------------------------
    // Round-robin arbitration from registered state
    //--------------------------------------------------------------------------
    assign rr_pref = (last_grant_q == SRC_LSB) ? SRC_ALU : SRC_LSB;

    always_comb begin
        grant_valid = 1'b0;
        grant_src   = SRC_ALU;
        if (fifo_ne[0] && fifo_ne[1]) begin
            grant_valid = 1'b1;
            grant_src   = rr_pref;
        end else if (fifo_ne[0]) begin
            grant_valid = 1'b1;
            grant_src   = SRC_ALU;
        end else if (fifo_ne[1]) begin
            grant_valid = 1'b1;
            grant_src   = SRC_LSB;
        end
    end

`ifdef CDB_BYPASS_EN
    always_comb begin
        byp_valid = 1'b0;
        byp_src   = SRC_ALU;
        if (!fifo_ne[0] && !fifo_ne[1] && (in_valid != 2'b00)) begin
            byp_valid = 1'b1;
            if (in_valid == 2'b11) begin
                byp_src = rr_pref;
            end else if (in_valid[1]) begin
                byp_src = SRC_LSB;
            end
        end
    end
`else
    assign byp_valid = 1'b0;
    assign byp_src   = SRC_ALU;
`endif

    // Full is judged on the pre-edge count, so a same-cycle pop never makes
    // room for a push. The bypassing source never enters its FIFO.
    always_comb begin
        push[0] = in_valid[0] && !fifo_full[0] && !(byp_valid && (byp_src == SRC_ALU));
        push[1] = in_valid[1] && !fifo_full[1] && !(byp_valid && (byp_src == SRC_LSB));
        pop[0]  = grant_valid && (grant_src == SRC_ALU);
        pop[1]  = grant_valid && (grant_src == SRC_LSB);
    end

    //--------------------------------------------------------------------------
    // Broadcast register, last grant, sticky overflow
    //--------------------------------------------------------------------------
    always_comb begin
        last_grant_d = last_grant_q;
        cdb_valid_d  = cdb_valid_q;
        cdb_src_d    = cdb_src_q;
        cdb_rob_id_d = cdb_rob_id_q;
        cdb_value_d  = cdb_value_q;
        overflow_d   = overflow_q;
        if (do_clear) begin
            last_grant_d = SRC_LSB;
            cdb_valid_d  = 1'b0;
            cdb_src_d    = SRC_ALU;
            cdb_rob_id_d = '0;
            cdb_value_d  = '0;
        end else if (do_step) begin
            if ((in_valid[0] && fifo_full[0]) || (in_valid[1] && fifo_full[1])) begin
                overflow_d = 1'b1;
            end
            if (grant_valid) begin
                last_grant_d = grant_src;
                cdb_valid_d  = 1'b1;
                cdb_src_d    = grant_src;
                cdb_rob_id_d = (grant_src == SRC_LSB) ? head_rob[1] : head_rob[0];
                cdb_value_d  = (grant_src == SRC_LSB) ? head_val[1] : head_val[0];
            end else if (byp_valid) begin
                last_grant_d = byp_src;
                cdb_valid_d  = 1'b1;
                cdb_src_d    = byp_src;
                cdb_rob_id_d = (byp_src == SRC_LSB) ? in_rob[1] : in_rob[0];
                cdb_value_d  = (byp_src == SRC_LSB) ? in_val[1] : in_val[0];
            end else begin
                cdb_valid_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            last_grant_q <= SRC_LSB;
            cdb_valid_q  <= 1'b0;
            cdb_src_q    <= SRC_ALU;
            cdb_rob_id_q <= '0;
            cdb_value_q  <= '0;
            overflow_q   <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            cdb_valid_q  <= cdb_valid_d;
            cdb_src_q    <= cdb_src_d;
            cdb_rob_id_q <= cdb_rob_id_d;
            cdb_value_q  <= cdb_value_d;
            overflow_q   <= overflow_d;
        end
    end

    assign cdb_valid    = cdb_valid_q;
    assign cdb_src      = cdb_src_q;
    assign cdb_rob_id   = cdb_rob_id_q;
    assign cdb_value    = cdb_value_q;
    assign overflow_err = overflow_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
`timescale 1ns/1ps

module tb_cdb_arbiter;

    localparam int unsigned ROB_W = 4;

    typedef struct packed {
        logic             src;
        logic [ROB_W-1:0] id;
        logic [31:0]      val;
    } exp_t;

    logic             clk_in = 1'b0;
    logic             rst_in;
    logic             rdy_in;
    logic             clear_in;
    logic             alu_valid;
    logic [ROB_W-1:0] alu_rob_id;
    logic [31:0]      alu_value;
    logic             alu_full;
    logic             lsb_valid;
    logic [ROB_W-1:0] lsb_rob_id;
    logic [31:0]      lsb_value;
    logic             lsb_full;
    logic             cdb_valid;
    logic             cdb_src;
    logic [ROB_W-1:0] cdb_rob_id;
    logic [31:0]      cdb_value;
    logic             overflow_err;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    cdb_arbiter #(
        .ROB_WIDTH (ROB_W),
        .FIFO_DEPTH(4)
    ) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .rdy_in      (rdy_in),
        .clear_in    (clear_in),
        .alu_valid   (alu_valid),
        .alu_rob_id  (alu_rob_id),
        .alu_value   (alu_value),
        .alu_full    (alu_full),
        .lsb_valid   (lsb_valid),
        .lsb_rob_id  (lsb_rob_id),
        .lsb_value   (lsb_value),
        .lsb_full    (lsb_full),
        .cdb_valid   (cdb_valid),
        .cdb_src     (cdb_src),
        .cdb_rob_id  (cdb_rob_id),
        .cdb_value   (cdb_value),
        .overflow_err(overflow_err)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [31:0] aval(input logic [ROB_W-1:0] id);
        return 32'hA000_0000 | {28'h0, id};
    endfunction

    function automatic logic [31:0] lval(input logic [ROB_W-1:0] id);
        return 32'h5000_0000 | {28'h0, id};
    endfunction

    task automatic tick;
        @(posedge clk_in);
        #1;
    endtask

    task automatic drive(input logic av, input logic [ROB_W-1:0] aid,
                         input logic lv, input logic [ROB_W-1:0] lid);
        alu_valid  = av;
        alu_rob_id = aid;
        alu_value  = aval(aid);
        lsb_valid  = lv;
        lsb_rob_id = lid;
        lsb_value  = lval(lid);
    endtask

    task automatic clear_pulse;
        clear_in = 1'b1;
        tick();
        clear_in = 1'b0;
    endtask

    //--------------------------------------------------------------------------
    task automatic test_reset;
        int bad;
        rst_in   = 1'b0;
        rdy_in   = 1'b1;
        clear_in = 1'b0;
        drive(1'b1, 4'd9, 1'b0, 4'd0);
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        checks++;
        if (cdb_valid !== 1'b0) begin failures++; $display("FAIL reset_cdb_valid: got %b expected 0", cdb_valid); end
        checks++;
        if (alu_full !== 1'b0) begin failures++; $display("FAIL reset_alu_full: got %b expected 0", alu_full); end
        checks++;
        if (lsb_full !== 1'b0) begin failures++; $display("FAIL reset_lsb_full: got %b expected 0", lsb_full); end
        checks++;
        if (overflow_err !== 1'b0) begin failures++; $display("FAIL reset_overflow: got %b expected 0", overflow_err); end
        tick();
        rst_in = 1'b1;
        drive(1'b0, 4'd0, 1'b0, 4'd0);
        bad = 0;
        repeat (4) begin
            @(negedge clk_in);
            if (cdb_valid !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL reset_idle: %0d broadcast cycles after release, expected 0", bad); end
    endtask

    //--------------------------------------------------------------------------
    task automatic test_single;
        exp_t e;
        tick();
        drive(1'b1, 4'd3, 1'b0, 4'd0);
        alu_value = 32'h0000_00AB;
        sb.push_back({1'b0, 4'd3, 32'h0000_00AB});
        tick();
        drive(1'b0, 4'd0, 1'b0, 4'd0);
        @(negedge clk_in);
`ifndef CDB_BYPASS_EN
        checks++;
        if (cdb_valid !== 1'b0) begin failures++; $display("FAIL single_latency: cdb_valid=%b one cycle early, expected 0", cdb_valid); end
        @(negedge clk_in);
`endif
        e = sb.pop_front();
        checks++;
        if (cdb_valid !== 1'b1 || {cdb_src, cdb_rob_id, cdb_value} !== e) begin
            failures++;
            $display("FAIL single_bcast: got v=%b src=%0d id=%0d val=%h expected v=1 src=%0d id=%0d val=%h",
                     cdb_valid, cdb_src, cdb_rob_id, cdb_value, e.src, e.id, e.val);
        end
        @(negedge clk_in);
        checks++;
        if (cdb_valid !== 1'b0) begin failures++; $display("FAIL single_after: cdb_valid=%b expected 0", cdb_valid); end
    endtask

    //--------------------------------------------------------------------------
    task automatic test_contention;
        exp_t e;
        exp_t act;
        int   got;
        int   first;
        int   lastc;
        tick();
        clear_pulse();
        got = 0; first = -1; lastc = -1;
        fork
            begin
                drive(1'b1, 4'd1, 1'b1, 4'd5);
                sb.push_back({1'b0, 4'd1, aval(4'd1)});
                sb.push_back({1'b1, 4'd5, lval(4'd5)});
                tick();
                drive(1'b1, 4'd2, 1'b1, 4'd6);
                sb.push_back({1'b0, 4'd2, aval(4'd2)});
                sb.push_back({1'b1, 4'd6, lval(4'd6)});
                tick();
                drive(1'b0, 4'd0, 1'b0, 4'd0);
            end
            begin
                for (int c = 0; c < 20 && got < 4; c++) begin
                    @(negedge clk_in);
                    if (cdb_valid === 1'b1) begin
                        if (first < 0) first = c;
                        lastc = c;
                        got++;
                        act = {cdb_src, cdb_rob_id, cdb_value};
                        checks++;
                        if (sb.size() == 0) begin
                            failures++;
                            $display("FAIL contention_bcast: unexpected broadcast src=%0d id=%0d", cdb_src, cdb_rob_id);
                        end else begin
                            e = sb.pop_front();
                            if (act !== e) begin
                                failures++;
                                $display("FAIL contention_bcast: got src=%0d id=%0d val=%h expected src=%0d id=%0d val=%h",
                                         act.src, act.id, act.val, e.src, e.id, e.val);
                            end
                        end
                    end
                end
            end
        join
        checks++;
        if (got != 4) begin failures++; $display("FAIL contention_count: got %0d broadcasts expected 4", got); end
        checks++;
        if (lastc - first != 3) begin failures++; $display("FAIL contention_b2b: span %0d cycles expected 3", lastc - first); end
        @(negedge clk_in);
        checks++;
        if (cdb_valid !== 1'b0) begin failures++; $display("FAIL contention_tail: cdb_valid=%b expected 0", cdb_valid); end
        checks++;
        if (sb.size() != 0) begin failures++; $display("FAIL contention_left: %0d expected entries left, expected 0", sb.size()); sb.delete(); end
    endtask

    //--------------------------------------------------------------------------
    // ALU keeps its FIFO occupied so the LSB only wins every other cycle;
    // LSB pushes ids 0..6 back to back, reaching full after id 5 and
    // dropping id 6.
    task automatic test_overflow;
        exp_t e;
        exp_t act;
        int   got;
        int   bad;
        tick();
        clear_pulse();
        got = 0;
        fork
            begin
                for (int k = 0; k < 7; k++) begin
                    checks++;
                    if (alu_full !== 1'b0) begin failures++; $display("FAIL ovf_alu_room k=%0d: alu_full=%b expected 0", k, alu_full); end
                    drive(1'b1, ROB_W'(8 + k), 1'b1, ROB_W'(k));
                    sb.push_back({1'b0, ROB_W'(8 + k), aval(ROB_W'(8 + k))});
                    if (k < 6) sb.push_back({1'b1, ROB_W'(k), lval(ROB_W'(k))});
                    tick();
                    if (k == 5) begin
                        checks++;
                        if (lsb_full !== 1'b1) begin failures++; $display("FAIL ovf_lsb_full: got %b expected 1", lsb_full); end
                        checks++;
                        if (overflow_err !== 1'b0) begin failures++; $display("FAIL ovf_early: overflow_err=%b expected 0", overflow_err); end
                    end
                end
                drive(1'b0, 4'd0, 1'b0, 4'd0);
                checks++;
                if (overflow_err !== 1'b1) begin failures++; $display("FAIL ovf_flag: overflow_err=%b expected 1", overflow_err); end
                checks++;
                if (lsb_full !== 1'b0) begin failures++; $display("FAIL ovf_lsb_after: lsb_full=%b expected 0", lsb_full); end
                checks++;
                if (alu_full !== 1'b1) begin failures++; $display("FAIL ovf_alu_full: alu_full=%b expected 1", alu_full); end
            end
            begin
                for (int c = 0; c < 40 && got < 13; c++) begin
                    @(negedge clk_in);
                    if (cdb_valid === 1'b1) begin
                        got++;
                        act = {cdb_src, cdb_rob_id, cdb_value};
                        checks++;
                        if (sb.size() == 0) begin
                            failures++;
                            $display("FAIL ovf_bcast: unexpected broadcast src=%0d id=%0d", cdb_src, cdb_rob_id);
                        end else begin
                            e = sb.pop_front();
                            if (act !== e) begin
                                failures++;
                                $display("FAIL ovf_bcast: got src=%0d id=%0d val=%h expected src=%0d id=%0d val=%h",
                                         act.src, act.id, act.val, e.src, e.id, e.val);
                            end
                        end
                    end
                end
            end
        join
        checks++;
        if (got != 13) begin failures++; $display("FAIL ovf_count: got %0d broadcasts expected 13", got); end
        bad = 0;
        repeat (3) begin
            @(negedge clk_in);
            if (cdb_valid !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL ovf_extra: %0d extra broadcasts expected 0", bad); end
        checks++;
        if (sb.size() != 0) begin failures++; $display("FAIL ovf_left: %0d expected entries left, expected 0", sb.size()); sb.delete(); end
    endtask

    //--------------------------------------------------------------------------
    task automatic test_clear;
        exp_t e;
        exp_t act;
        int   got;
        int   bad;
        tick();
        clear_pulse();
        got = 0;
        fork
            begin
                for (int k = 0; k < 5; k++) begin
                    drive(1'b1, ROB_W'(1 + k), 1'b1, ROB_W'(9 + k));
                    if (k < 2) begin
                        sb.push_back({1'b0, ROB_W'(1 + k), aval(ROB_W'(1 + k))});
                        sb.push_back({1'b1, ROB_W'(9 + k), lval(ROB_W'(9 + k))});
                    end
                    tick();
                end
                // inputs presented in the flush cycle must be discarded
                drive(1'b1, 4'd6, 1'b1, 4'd14);
                clear_in = 1'b1;
                tick();
                clear_in = 1'b0;
                drive(1'b0, 4'd0, 1'b0, 4'd0);
                checks++;
                if (cdb_valid !== 1'b0) begin failures++; $display("FAIL clear_cdb_valid: got %b expected 0", cdb_valid); end
                checks++;
                if (alu_full !== 1'b0 || lsb_full !== 1'b0) begin
                    failures++; $display("FAIL clear_full: alu_full=%b lsb_full=%b expected 0 0", alu_full, lsb_full);
                end
                checks++;
                if (overflow_err !== 1'b1) begin failures++; $display("FAIL clear_keeps_ovf: overflow_err=%b expected 1", overflow_err); end
            end
            begin
                for (int c = 0; c < 20 && got < 4; c++) begin
                    @(negedge clk_in);
                    if (cdb_valid === 1'b1) begin
                        got++;
                        act = {cdb_src, cdb_rob_id, cdb_value};
                        checks++;
                        if (sb.size() == 0) begin
                            failures++;
                            $display("FAIL clear_bcast: unexpected broadcast src=%0d id=%0d", cdb_src, cdb_rob_id);
                        end else begin
                            e = sb.pop_front();
                            if (act !== e) begin
                                failures++;
                                $display("FAIL clear_bcast: got src=%0d id=%0d val=%h expected src=%0d id=%0d val=%h",
                                         act.src, act.id, act.val, e.src, e.id, e.val);
                            end
                        end
                    end
                end
            end
        join
        checks++;
        if (got != 4) begin failures++; $display("FAIL clear_count: got %0d broadcasts expected 4", got); end
        bad = 0;
        repeat (8) begin
            @(negedge clk_in);
            if (cdb_valid !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL clear_flushed: %0d broadcasts after flush expected 0", bad); end
        checks++;
        if (sb.size() != 0) begin failures++; $display("FAIL clear_left: %0d expected entries left, expected 0", sb.size()); sb.delete(); end
    endtask

    //--------------------------------------------------------------------------
    task automatic test_freeze;
        exp_t e;
        exp_t act;
        int   got;
        tick();
        clear_pulse();
        drive(1'b1, 4'd7, 1'b1, 4'd1);
        sb.push_back({1'b0, 4'd7, aval(4'd7)});
        sb.push_back({1'b1, 4'd1, lval(4'd1)});
        tick();
        drive(1'b1, 4'd8, 1'b1, 4'd2);
        sb.push_back({1'b0, 4'd8, aval(4'd8)});
        sb.push_back({1'b1, 4'd2, lval(4'd2)});
        tick();
        // frozen cycles: these inputs must be ignored
        rdy_in = 1'b0;
        drive(1'b1, 4'd15, 1'b1, 4'd15);
        @(negedge clk_in);
        e = sb.pop_front();
        checks++;
        if (cdb_valid !== 1'b1 || {cdb_src, cdb_rob_id, cdb_value} !== e) begin
            failures++;
            $display("FAIL freeze_first: got v=%b src=%0d id=%0d val=%h expected v=1 src=%0d id=%0d val=%h",
                     cdb_valid, cdb_src, cdb_rob_id, cdb_value, e.src, e.id, e.val);
        end
        for (int f = 0; f < 3; f++) begin
            @(posedge clk_in);
            @(negedge clk_in);
            checks++;
            if (cdb_valid !== 1'b1 || cdb_src !== 1'b0 || cdb_rob_id !== 4'd7 || cdb_value !== aval(4'd7)) begin
                failures++;
                $display("FAIL freeze_hold f=%0d: got v=%b src=%0d id=%0d val=%h expected v=1 src=0 id=7 val=%h",
                         f, cdb_valid, cdb_src, cdb_rob_id, cdb_value, aval(4'd7));
            end
        end
        rdy_in = 1'b1;
        drive(1'b0, 4'd0, 1'b0, 4'd0);
        got = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_in);
            act = {cdb_src, cdb_rob_id, cdb_value};
            checks++;
            if (cdb_valid !== 1'b1 || sb.size() == 0) begin
                failures++;
                $display("FAIL freeze_resume c=%0d: cdb_valid=%b queued=%0d expected v=1 with entry pending", c, cdb_valid, sb.size());
            end else begin
                got++;
                e = sb.pop_front();
                if (act !== e) begin
                    failures++;
                    $display("FAIL freeze_resume c=%0d: got src=%0d id=%0d val=%h expected src=%0d id=%0d val=%h",
                             c, act.src, act.id, act.val, e.src, e.id, e.val);
                end
            end
        end
        @(negedge clk_in);
        checks++;
        if (cdb_valid !== 1'b0) begin failures++; $display("FAIL freeze_tail: cdb_valid=%b expected 0", cdb_valid); end
        checks++;
        if (sb.size() != 0) begin failures++; $display("FAIL freeze_left: %0d expected entries left, expected 0", sb.size()); sb.delete(); end
    endtask

    //--------------------------------------------------------------------------
    initial begin
        test_reset();
        test_single();
        test_contention();
        test_overflow();
        test_clear();
        test_freeze();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
